// File: rtl/cpu_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg                                                               |
// | State encoding, opcode constants and IR field layout for control_sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_ctrl_pkg;

  localparam int OP_W      = 5;
  localparam int REG_IDX_W = 4;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  // Ops whose result fits in Zlow and lands in a general register
  function automatic logic is_single(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_hilo(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_MUL, OP_DIV: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_select_decoder.sv
// +----------------------------------------------------------------------------+
// | reg_select_decoder                                                         |
// | Register index to one-hot select, all-zero when disabled                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_select_decoder #(
  parameter int NREG = 16,
  parameter int IDXW = 4
) (
  input  logic [IDXW-1:0] index,
  input  logic            enable,
  output logic [NREG-1:0] onehot
);

  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_bit
      assign onehot[i] = enable && (index == IDXW'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// +----------------------------------------------------------------------------+
// | control_sequencer                                                          |
// | Moore control unit: fetch plus register-register ALU execute (T0..T6)      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic            fault
);

  state_t r_state;
  state_t w_next;
  logic   r_fault;
  logic   r_t1_wait;
  logic   r_halt_armed;

  logic [OP_W-1:0]      w_op;
  logic [REG_IDX_W-1:0] w_ra;
  logic [REG_IDX_W-1:0] w_rb;
  logic [REG_IDX_W-1:0] w_rc;
  logic                 w_unused_ir;

  logic                 w_rin_en;
  logic [REG_IDX_W-1:0] w_rin_idx;
  logic                 w_rout_en;
  logic [REG_IDX_W-1:0] w_rout_idx;

  assign w_op        = ir[OP_LSB +: OP_W];
  assign w_ra        = ir[RA_LSB +: REG_IDX_W];
  assign w_rb        = ir[RB_LSB +: REG_IDX_W];
  assign w_rc        = ir[RC_LSB +: REG_IDX_W];
  assign w_unused_ir = ^ir[RC_LSB-1:0];

  // r_t1_wait marks repeat T1 cycles; r_halt_armed records start=0 seen in HALT
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state      <= S_IDLE;
      r_fault      <= 1'b0;
      r_t1_wait    <= 1'b0;
      r_halt_armed <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fault      <= r_fault | (w_next == S_FAULT);
      r_t1_wait    <= (r_state == S_T1);
      r_halt_armed <= (r_state == S_HALT) && !start;
    end
  end

  always_comb begin
    w_next     = r_state;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    alu_op     = '0;
    w_rin_en   = 1'b0;
    w_rin_idx  = w_ra;
    w_rout_en  = 1'b0;
    w_rout_idx = w_rb;

    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_T0;
      end
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = !r_t1_wait;
        if (mem_ready) w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (is_single(w_op) || is_hilo(w_op)) begin
          w_rout_en  = 1'b1;
          w_rout_idx = w_rb;
          Yin        = 1'b1;
          w_next     = S_T4;
        end else if (w_op == OP_NOP) begin
          w_next = S_T0;
        end else if (w_op == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          w_next = S_FAULT;
        end
      end
      S_T4: begin
        w_rout_en  = 1'b1;
        w_rout_idx = w_rc;
        Zin        = 1'b1;
        alu_op     = OPW'(w_op);
        w_next     = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_hilo(w_op)) begin
          LOin   = 1'b1;
          w_next = S_T6;
        end else begin
          w_rin_en  = 1'b1;
          w_rin_idx = w_ra;
          w_next    = start ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        w_next   = start ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        if (r_halt_armed && start) w_next = S_T0;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign run   = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);
  assign fault = r_fault;

  reg_select_decoder #(
    .NREG (NREG),
    .IDXW (REG_IDX_W)
  ) u_rin_dec (
    .index  (w_rin_idx),
    .enable (w_rin_en),
    .onehot (Rin)
  );

  reg_select_decoder #(
    .NREG (NREG),
    .IDXW (REG_IDX_W)
  ) u_rout_dec (
    .index  (w_rout_idx),
    .enable (w_rout_en),
    .onehot (Rout)
  );

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_control_sequencer                                                       |
// | Directed self-checking bench for control_sequencer                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  alu_op;
  logic        run;
  logic        fault;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [13:0] M_PCOUT  = 14'h2000;
  localparam logic [13:0] M_PCIN   = 14'h1000;
  localparam logic [13:0] M_INCPC  = 14'h0800;
  localparam logic [13:0] M_MARIN  = 14'h0400;
  localparam logic [13:0] M_READ   = 14'h0200;
  localparam logic [13:0] M_MDRIN  = 14'h0100;
  localparam logic [13:0] M_MDROUT = 14'h0080;
  localparam logic [13:0] M_IRIN   = 14'h0040;
  localparam logic [13:0] M_YIN    = 14'h0020;
  localparam logic [13:0] M_ZIN    = 14'h0010;
  localparam logic [13:0] M_ZLOW   = 14'h0008;
  localparam logic [13:0] M_ZHIGH  = 14'h0004;
  localparam logic [13:0] M_HIIN   = 14'h0002;
  localparam logic [13:0] M_LOIN   = 14'h0001;

  localparam logic [13:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [13:0] E_T1  = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [13:0] E_T1W = M_READ | M_MDRIN;
  localparam logic [13:0] E_T2  = M_MDROUT | M_IRIN;

  control_sequencer #(.OPW(5), .NREG(16)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .ir        (ir),
    .mem_ready (mem_ready),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .Read      (Read),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .Zlowout   (Zlowout),
    .Zhighout  (Zhighout),
    .HIin      (HIin),
    .LOin      (LOin),
    .Rin       (Rin),
    .Rout      (Rout),
    .alu_op    (alu_op),
    .run       (run),
    .fault     (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // dc masks strobe bits whose value is not pinned down for that cycle
  task automatic chk(input string tag, input logic [13:0] es, input logic [13:0] dc,
                     input logic [15:0] erin, input logic [15:0] erout,
                     input logic [4:0] ealu, input logic erun, input logic efault);
    logic [52:0] obs;
    logic [52:0] exp;
    obs = {{PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
            Yin, Zin, Zlowout, Zhighout, HIin, LOin} & ~dc,
           Rin, Rout, alu_op, run, fault};
    exp = {es & ~dc, erin, erout, ealu, erun, efault};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clear     = 1'b0;
    start     = 1'b1;
    ir        = 32'h0;
    mem_ready = 1'b0;

    step();
    chk("reset_c1", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    step();
    chk("reset_c2", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    chk("t0_after_reset", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    // AND R1 <- R2 & R3
    ir = 32'h28918000;
    mem_ready = 1'b1;
    step(); chk("and_t1", E_T1, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("and_t2", E_T2, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("and_t3", M_YIN, 14'h0, 16'h0, 16'h0004, 5'h0, 1'b1, 1'b0);
    step(); chk("and_t4", M_ZIN, 14'h0, 16'h0, 16'h0008, 5'b00101, 1'b1, 1'b0);
    step(); chk("and_t5", M_ZLOW, 14'h0, 16'h0002, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("and_next_t0", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    // NOP with three memory wait cycles
    ir = 32'hD0000000;
    mem_ready = 1'b0;
    step(); chk("wait_t1_first", E_T1, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("wait_t1_w1", E_T1W, M_ZLOW, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("wait_t1_w2", E_T1W, M_ZLOW, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("wait_t1_w3", E_T1W, M_ZLOW, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    step(); chk("wait_t2", E_T2, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("nop_t3", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("nop_next_t0", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    // MUL ra=4 rb=5 rc=6
    ir = 32'h7A2B0000;
    step(); chk("mul_t1", E_T1, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("mul_t2", E_T2, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("mul_t3", M_YIN, 14'h0, 16'h0, 16'h0020, 5'h0, 1'b1, 1'b0);
    step(); chk("mul_t4", M_ZIN, 14'h0, 16'h0, 16'h0040, 5'b01111, 1'b1, 1'b0);
    step(); chk("mul_t5", M_ZLOW | M_LOIN, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("mul_t6", M_ZHIGH | M_HIIN, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("mul_next_t0", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    // ADD R0 <- R15 + R0, start dropped mid-instruction
    ir = 32'h18780000;
    step(); chk("add_t1", E_T1, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("add_t2", E_T2, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk("add_t3", M_YIN, 14'h0, 16'h0, 16'h8000, 5'h0, 1'b1, 1'b0);
    step(); chk("add_t4", M_ZIN, 14'h0, 16'h0, 16'h0001, 5'b00011, 1'b1, 1'b0);
    step(); chk("add_t5", M_ZLOW, 14'h0, 16'h0001, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("add_to_idle", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    step(); chk("idle_hold", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    start = 1'b1;
    step(); chk("idle_to_t0", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    // Illegal opcode 11111
    ir = 32'hF8000000;
    step(); chk("ill_t1", E_T1, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("ill_t2", E_T2, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("ill_t3", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("fault_enter", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1);
    start = 1'b0;
    step(); chk("fault_start0", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1);
    start = 1'b1;
    step(); chk("fault_start1", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1);
    step(); chk("fault_sticky", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1);
    clear = 1'b0;
    step(); chk("fault_cleared", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    clear = 1'b1;
    step(); chk("clear_to_t0", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    // HALT then restart on a fresh start edge
    ir = 32'hD8000000;
    step(); chk("halt_t1", E_T1, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("halt_t2", E_T2, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("halt_t3", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    step(); chk("halt_enter", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    step(); chk("halt_start_held", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    start = 1'b0;
    step(); chk("halt_start_low", 14'h0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    start = 1'b1;
    step(); chk("halt_restart_t0", E_T0, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath control strobes for the instruction fetch and the register-register ALU execute sequence.
- Steps a Moore state machine T0..T6 per instruction and waits on a memory-ready handshake during fetch.
- Decodes IR fields into one-hot register in/out selects and an ALU opcode.
- Sits beside the Datapath; its outputs connect 1:1 to the Datapath control inputs.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- NREG, 16, number of general registers (one-hot select width).

Ports:
- clock  in  1  system clock, all state updates on its rising edge.
- clear  in  1  reset, synchronous, active-low.
- start  in  1  level; leaving IDLE requires start=1.
- ir  in  32  instruction register contents from the Datapath.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  Datapath strobes.
- Rin  out  NREG  one-hot register load select.
- Rout  out  NREG  one-hot register bus-drive select.
- alu_op  out  OPW  operation presented to the ALU; valid when Zin=1.
- run  out  1  high from T0 until HALT/FAULT/IDLE.
- fault  out  1  sticky illegal-opcode flag.

Behaviour:
- clear=0 at a rising edge: state<=IDLE, fault<=0. All outputs are 0 in IDLE, including Rin, Rout, alu_op and run.
- Reset mid-instruction aborts immediately; no partial strobes appear in the following cycle.
- IR fields:
  - op = ir[31:27]
  - ra = ir[26:23] (destination)
  - rb = ir[22:19]
  - rc = ir[18:15]
- Opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110 (single-result group)
  - MUL 01111, DIV 10000 (HI/LO group)
  - NOP 11010, HALT 11011
  - any other value is illegal.
- Outputs are a pure function of state, op and the fields (Moore). Each state lasts one cycle unless noted.
- IDLE: go to T0 when start=1.
- T0: PCout, MARin, IncPC, Zin=1; alu_op=0.
- T1: Zlowout, PCin, Read, MDRin=1.
  - Stay in T1 while mem_ready=0, holding Read and MDRin.
  - PCin is asserted only in the first T1 cycle, so PC is never loaded twice.
  - Advance to T2 when mem_ready=1.
- T2: MDRout, IRin=1.
  - ir is sampled by the decode logic from T3 on.
- T3: dispatch on op.
  - ALU ops: Rout[rb]=1, Yin=1.
  - NOP: go to T0; no strobes in T3.
  - HALT: go to HALT.
  - Illegal: go to FAULT.
- T4: Rout[rc]=1, Zin=1, alu_op=op.
- T5:
  - Single-result group: Zlowout=1, Rin[ra]=1, then go to T0.
  - MUL/DIV: Zlowout=1, LOin=1, then go to T6.
- T6: Zhighout=1, HIin=1, then go to T0.
- HALT: outputs 0, run=0. Return to T0 only on a new start rising edge (start sampled 0 then 1).
- FAULT: outputs 0, run=0, fault=1. Leaves only via clear=0.
- start deasserted mid-instruction: the current instruction completes. At the end of T5/T6, return to IDLE if start=0, else continue to T0.
- Rin and Rout are always one-hot or all-zero. Rin is nonzero only in T5 of the single-result group.
- Writing R0 is allowed; the Datapath owns any R0 semantics.
- Instruction latency with mem_ready high in the first T1 cycle:
  - single-result ALU op: 6 cycles
  - MUL/DIV: 7 cycles
  - NOP: 4 cycles
- Each extra wait cycle in T1 adds 1 cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enumeration: IDLE, T0..T6, HALT, FAULT (4-bit encoding)
  - opcode constants
  - IR field bit positions.
- Sub-module reg_select_decoder: 4-bit index plus enable in, NREG one-hot out. Instantiated twice, once for Rin and once for Rout.

Test Plan:
- Reset: hold clear=0 for 2 cycles with start=1 -> all outputs 0, fault=0. Release clear -> T0 strobes (PCout, MARin, IncPC, Zin) on the next cycle.
- AND fetch/execute: ir=32'h28918000, mem_ready=1 at T1 ->
  - T3: Rout=16'h0004, Yin=1
  - T4: Rout=16'h0008, Zin=1, alu_op=5'b00101
  - T5: Rin=16'h0002, Zlowout=1
  - 6 cycles total.
- Memory wait: mem_ready low for 3 cycles in T1 -> Read and MDRin held 4 cycles, PCin high only in the first, IRin asserted exactly once.
- MUL: op=01111 -> T5 asserts Zlowout+LOin, T6 asserts Zhighout+HIin, Rin stays 0 throughout, next state T0.
- Illegal op 11111 -> FAULT after T3, fault=1 and run=0. start toggling has no effect; clear=0 restores IDLE with fault=0.
- HALT then restart: op=11011 -> run=0. start held 1 keeps HALT; start 0->1 -> T0 on the next cycle.
